// File: rtl/ro_uart_framer.sv
// Ring-oscillator sample framer: 6-byte 8N1 UART frame per accepted sample.
// Frame: A5, d[31:24], d[23:16], d[15:8], d[7:0], xor of the four data bytes.
module ro_uart_framer #(
  parameter int CLK_DIV = 868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample_valid,
  input  logic [31:0] sample_data,
  output logic        sample_ready,
  output logic        txd,
  output logic        busy,
  output logic        frame_sent
);

  localparam int BW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [BW-1:0] BMAX = BW'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t      state;
  logic [BW-1:0] baud;
  logic [2:0]  bit_idx;
  logic [2:0]  byte_idx;
  logic [31:0] data;
  logic [7:0]  cur;
  logic [7:0]  chk;
  logic [2:0]  bit_nxt;
  logic        tick;

  assign chk = data[31:24] ^ data[23:16] ^ data[15:8] ^ data[7:0];
  assign tick = (baud == BMAX);
  assign bit_nxt = bit_idx + 3'd1;

  always_comb begin
    cur = 8'hA5;
    unique case (byte_idx)
      3'd1:    cur = data[31:24];
      3'd2:    cur = data[23:16];
      3'd3:    cur = data[15:8];
      3'd4:    cur = data[7:0];
      3'd5:    cur = chk;
      default: cur = 8'hA5;
    endcase
  end

  // txd is loaded one edge ahead with the level of the bit about to start
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      baud         <= '0;
      bit_idx      <= '0;
      byte_idx     <= '0;
      data         <= '0;
      txd          <= 1'b1;
      sample_ready <= 1'b0;
      busy         <= 1'b0;
      frame_sent   <= 1'b0;
    end else begin
      frame_sent <= 1'b0;
      unique case (state)
        IDLE: begin
          txd          <= 1'b1;
          busy         <= 1'b0;
          sample_ready <= 1'b1;
          if (sample_valid && sample_ready) begin
            data         <= sample_data;
            byte_idx     <= '0;
            baud         <= '0;
            txd          <= 1'b0;
            busy         <= 1'b1;
            sample_ready <= 1'b0;
            state        <= START;
          end
        end
        START: begin
          if (tick) begin
            baud    <= '0;
            bit_idx <= '0;
            txd     <= cur[0];
            state   <= DATA;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        DATA: begin
          if (tick) begin
            baud <= '0;
            if (bit_idx == 3'd7) begin
              txd   <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_nxt;
              txd     <= cur[bit_nxt];
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        STOP: begin
          if (tick) begin
            baud <= '0;
            if (byte_idx < 3'd5) begin
              byte_idx <= byte_idx + 3'd1;
              txd      <= 1'b0;
              state    <= START;
            end else begin
              byte_idx     <= '0;
              busy         <= 1'b0;
              sample_ready <= 1'b1;
              frame_sent   <= 1'b1;
              state        <= IDLE;
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
